mux_sel_scanner: RTL and testbench
==================================

// Module: mux_sel_scanner
// PURPOSE
//  Sequencer feeding the select inputs (S1,S0 / A,B) of the 4x1 mux function stage.
//  Sweeps every select code, waits a settle window, samples the stage output f and
//  assembles the truth-table word. Compares that word with an expected pattern.
//  Lab self-check driver for mux-based logic functions; start/busy/done handshake.
// PARAMETERS
//  N_SEL       2   select width; table width TT_W = 2**N_SEL (legal 1..4)
//  SETTLE_CYC  1   cycles select is held before sampling f_in (legal 1..15)
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       synchronous reset, active-low
//  start          in   1       request a sweep; accepted only in IDLE
//  expected       in   TT_W    golden truth table, bit i = f for sel_out==i
//  f_in           in   1       output of the mux function stage
//  sel_out        out  N_SEL   select code to stage; sel_out[1]=S1/A, [0]=S0/B
//  busy           out  1       high from start acceptance until DONE exits
//  done           out  1       one-cycle pulse, results valid
//  tt_word        out  TT_W    captured truth table
//  match          out  1       tt_word == captured expected
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-low (rst_n); reset wins over all inputs.
//  - Reset values: sel_out=0, busy=0, done=0, tt_word=0, match=0, state=IDLE.
//  - FSM: IDLE -> DRIVE -> SAMPLE -> (DRIVE | DONE) -> IDLE.
//    IDLE:   start=1 -> register expected, clear tt_word/match, idx=0, cnt=SETTLE_CYC, DRIVE.
//    DRIVE:  sel_out=idx; cnt decrements each cycle; on cnt==1 go SAMPLE.
//    SAMPLE: tt_word[idx]<=f_in; idx==TT_W-1 -> DONE, else idx++, cnt reloads, DRIVE.
//    DONE:   done=1 one cycle; match=(tt_word==expected_q); -> IDLE.
//  - sel_out changes only on DRIVE entry; held stable through DRIVE and SAMPLE.
//  - Latency: with start sampled at edge 0, done is high in the cycle after edge
//    (SETTLE_CYC+1)*TT_W (default: after edge 8).
//  - busy=1 in DRIVE/SAMPLE/DONE; start ignored while busy (no queueing).
//  - expected changes after start acceptance have no effect on the running sweep.
//  - tt_word/match hold last result in IDLE until next accepted start.
//  - idx wraps nowhere: the sweep ends at TT_W-1; sel_out returns to 0 in IDLE.
//  - rst_n low mid-sweep: abort, no done pulse, all outputs to reset values.
// CONFIGURATION
//  SCAN_FIRSTERR_EN defined: adds outputs first_err_vld (1) and first_err_idx (N_SEL);
//    at DONE, report the lowest i with tt_word[i]!=expected_q[i]; vld=0 on match;
//    both cleared at reset and start acceptance, held otherwise.
//  Not defined: ports absent, only match reports the comparison.
// STRUCTURE
//  - Shared package (Verilog include): FSM state encodings (IDLE/DRIVE/SAMPLE/DONE,
//    2 bits), SETTLE_CYC counter width constant.
//  - One natural sub-module: scan_settle_timer (loadable down-counter, pulses at 1).
//  - Datapath (idx, tt_word, compare) stays in top; no other hierarchy.
// TESTING
//  1. f=~B stage (E=1,0,1,0), expected=4'b0101, start pulse -> sel_out 0,1,2,3;
//     tt_word=4'b0101, match=1, done after edge 8.
//  2. Same stage, expected=4'b0110 -> tt_word=4'b0101, match=0;
//     with SCAN_FIRSTERR_EN first_err_vld=1, first_err_idx=0.
//  3. start held high through sweep -> exactly one sweep, one done pulse; new sweep
//     only after start seen in IDLE again.
//  4. rst_n low at edge 3 of sweep -> next cycle busy=0, sel_out=0, tt_word=0,
//     no done pulse; fresh start runs full sweep.
//  5. SETTLE_CYC=3, f_in forced to 1 -> each sel_out held 4 cycles, done after
//     edge 16, tt_word=4'b1111.
//  6. start and rst_n=0 same edge -> reset wins, stays IDLE, busy=0.

Source files
------------

// File: rtl/mux_sel_scanner_pkg.sv
// Shared definitions for the mux select scanner: FSM state encoding and settle counter width.
package mux_sel_scanner_pkg;

  // Wide enough for the largest settle window (15 cycles).
  localparam int unsigned SettleCntW = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDrive  = 2'd1,
    StSample = 2'd2,
    StDone   = 2'd3
  } scan_state_e;

endpackage

// File: rtl/scan_settle_timer.sv
// Loadable down-counter that flags when the settle window is in its final cycle (count == 1).
module scan_settle_timer
  import mux_sel_scanner_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  dec,
  input  logic [SettleCntW-1:0] load_val,
  output logic                  hit
);

  logic [SettleCntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == SettleCntW'(1));

endmodule

// File: rtl/mux_sel_scanner.sv
// Sweeps every select code of a 4x1 mux function stage, samples f_in and checks the truth table.
// Optional SCAN_FIRSTERR_EN adds first_err_vld/first_err_idx reporting the lowest mismatching bit.
module mux_sel_scanner
  import mux_sel_scanner_pkg::*;
#(
  parameter int unsigned N_SEL      = 2,
  parameter int unsigned SETTLE_CYC = 1,
  localparam int unsigned TT_W      = 1 << N_SEL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [TT_W-1:0]  expected,
  input  logic             f_in,
  output logic [N_SEL-1:0] sel_out,
  output logic             busy,
  output logic             done,
  output logic [TT_W-1:0]  tt_word,
  output logic             match
`ifdef SCAN_FIRSTERR_EN
  ,
  output logic             first_err_vld,
  output logic [N_SEL-1:0] first_err_idx
`endif
);

  scan_state_e      state_q, state_d;
  logic [N_SEL-1:0] idx_q, idx_d;
  logic [TT_W-1:0]  tt_q, tt_d;
  logic [TT_W-1:0]  exp_q, exp_d;
  logic             match_q, match_d;
  logic             tmr_load, tmr_dec, tmr_hit;
  logic             last_idx;

  assign last_idx = (idx_q == N_SEL'(TT_W - 1));

  scan_settle_timer u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (SettleCntW'(SETTLE_CYC)),
    .hit      (tmr_hit)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tt_d     = tt_q;
    exp_d    = exp_q;
    match_d  = match_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          exp_d    = expected;
          tt_d     = '0;
          match_d  = 1'b0;
          idx_d    = '0;
          tmr_load = 1'b1;
          state_d  = StDrive;
        end
      end
      StDrive: begin
        tmr_dec = 1'b1;
        if (tmr_hit) begin
          state_d = StSample;
        end
      end
      StSample: begin
        tt_d[idx_q] = f_in;
        if (last_idx) begin
          // Compare against the final word so match is valid while done is high.
          match_d = (tt_d == exp_q);
          state_d = StDone;
        end else begin
          idx_d    = idx_q + 1'b1;
          tmr_load = 1'b1;
          state_d  = StDrive;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      tt_q    <= '0;
      exp_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tt_q    <= tt_d;
      exp_q   <= exp_d;
      match_q <= match_d;
    end
  end

`ifdef SCAN_FIRSTERR_EN
  logic             fe_vld_q, fe_vld_d;
  logic [N_SEL-1:0] fe_idx_q, fe_idx_d;
  logic [TT_W-1:0]  diff;
  logic             scan_vld;
  logic [N_SEL-1:0] scan_idx;

  assign diff = tt_d ^ exp_q;

  // Walk downward so the lowest mismatching index is the one left standing.
  always_comb begin
    scan_vld = 1'b0;
    scan_idx = '0;
    for (int i = TT_W - 1; i >= 0; i--) begin
      if (diff[i]) begin
        scan_vld = 1'b1;
        scan_idx = N_SEL'(i);
      end
    end
  end

  always_comb begin
    fe_vld_d = fe_vld_q;
    fe_idx_d = fe_idx_q;
    if ((state_q == StIdle) && start) begin
      fe_vld_d = 1'b0;
      fe_idx_d = '0;
    end else if ((state_q == StSample) && last_idx) begin
      fe_vld_d = scan_vld;
      fe_idx_d = scan_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fe_vld_q <= 1'b0;
      fe_idx_q <= '0;
    end else begin
      fe_vld_q <= fe_vld_d;
      fe_idx_q <= fe_idx_d;
    end
  end

  assign first_err_vld = fe_vld_q;
  assign first_err_idx = fe_idx_q;
`endif

  // idx only advances on the SAMPLE->DRIVE edge, so sel_out is stable across a whole step.
  assign sel_out = ((state_q == StDrive) || (state_q == StSample)) ? idx_q : '0;
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign tt_word = tt_q;
  assign match   = match_q;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Directed bench for mux_sel_scanner: default settle DUT on an f=~B stage, settle-3 DUT on f=1.
module tb_mux_sel_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start2;
  logic [3:0] expected, expected2;
  logic       f_in, f_in2;
  logic [1:0] sel_out, sel_out2;
  logic       busy, busy2, done, done2, match, match2;
  logic [3:0] tt_word, tt_word2;
`ifdef SCAN_FIRSTERR_EN
  logic       fe_vld, fe_vld2;
  logic [1:0] fe_idx, fe_idx2;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // Stage E=1,0,1,0 -> f = ~B, where B = sel_out[0].
  assign f_in  = ~sel_out[0];
  assign f_in2 = 1'b1;

  mux_sel_scanner #(.N_SEL(2), .SETTLE_CYC(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .expected (expected),
    .f_in     (f_in),
    .sel_out  (sel_out),
    .busy     (busy),
    .done     (done),
    .tt_word  (tt_word),
    .match    (match)
`ifdef SCAN_FIRSTERR_EN
    ,
    .first_err_vld (fe_vld),
    .first_err_idx (fe_idx)
`endif
  );

  mux_sel_scanner #(.N_SEL(2), .SETTLE_CYC(3)) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start2),
    .expected (expected2),
    .f_in     (f_in2),
    .sel_out  (sel_out2),
    .busy     (busy2),
    .done     (done2),
    .tt_word  (tt_word2),
    .match    (match2)
`ifdef SCAN_FIRSTERR_EN
    ,
    .first_err_vld (fe_vld2),
    .first_err_idx (fe_idx2)
`endif
  );

  // Start a sweep on the settle-1 DUT; returns edges from acceptance to done (bounded).
  task automatic sweep1(input logic [3:0] e, output int cyc);
    @(negedge clk);
    expected = e;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!done && cyc < 40);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    expected = 4'h0; expected2 = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    checks++; if (sel_out !== 2'd0) $display("FAIL reset_sel: got %0d want 0", sel_out);
    else passed++;
    checks++; if (tt_word !== 4'h0) $display("FAIL reset_tt: got %b want 0000", tt_word);
    else passed++;
    checks++; if (match !== 1'b0) $display("FAIL reset_match: got %b want 0", match);
    else passed++;
    checks++; if (busy2 !== 1'b0) $display("FAIL reset_busy2: got %b want 0", busy2);
    else passed++;
`ifdef SCAN_FIRSTERR_EN
    checks++; if (fe_vld !== 1'b0) $display("FAIL reset_fe_vld: got %b want 0", fe_vld);
    else passed++;
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int  cyc;
    logic [1:0] want_sel;
    @(negedge clk);
    expected = 4'b0101;
    start    = 1'b1;
    @(posedge clk);
    // Changing expected after acceptance must not affect the sweep.
    #1 start = 1'b0;
    expected = 4'b0000;
    @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else passed++;
    checks++; if (sel_out !== 2'd0) $display("FAIL basic_sel_e0: got %0d want 0", sel_out);
    else passed++;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (!done && cyc < 8) begin
        want_sel = 2'(cyc / 2);
        checks++;
        if (sel_out !== want_sel)
          $display("FAIL basic_sel_e%0d: got %0d want %0d", cyc, sel_out, want_sel);
        else passed++;
      end
    end
    checks++; if (cyc !== 8) $display("FAIL basic_latency: got %0d want 8", cyc); else passed++;
    checks++; if (tt_word !== 4'b0101) $display("FAIL basic_tt: got %b want 0101", tt_word);
    else passed++;
    checks++; if (match !== 1'b1) $display("FAIL basic_match: got %b want 1", match); else passed++;
`ifdef SCAN_FIRSTERR_EN
    checks++; if (fe_vld !== 1'b0) $display("FAIL basic_fe_vld: got %b want 0", fe_vld);
    else passed++;
`endif
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done);
    else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_idle_busy: got %b want 0", busy);
    else passed++;
    checks++; if (sel_out !== 2'd0) $display("FAIL basic_idle_sel: got %0d want 0", sel_out);
    else passed++;
    checks++; if (tt_word !== 4'b0101) $display("FAIL basic_hold_tt: got %b want 0101", tt_word);
    else passed++;
  endtask

  task automatic test_mismatch;
    int cyc;
    sweep1(4'b0110, cyc);
    checks++; if (cyc !== 8) $display("FAIL mis_latency: got %0d want 8", cyc); else passed++;
    checks++; if (tt_word !== 4'b0101) $display("FAIL mis_tt: got %b want 0101", tt_word);
    else passed++;
    checks++; if (match !== 1'b0) $display("FAIL mis_match: got %b want 0", match); else passed++;
`ifdef SCAN_FIRSTERR_EN
    checks++; if (fe_vld !== 1'b1) $display("FAIL mis_fe_vld: got %b want 1", fe_vld);
    else passed++;
    checks++; if (fe_idx !== 2'd0) $display("FAIL mis_fe_idx: got %0d want 0", fe_idx);
    else passed++;
`endif
  endtask

  task automatic test_start_held;
    int n_done;
    n_done = 0;
    @(negedge clk);
    expected = 4'b0101;
    start    = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) n_done++;
    end
    start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) n_done++;
    end
    checks++; if (n_done !== 1) $display("FAIL held_done_count: got %0d want 1", n_done);
    else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL held_busy_end: got %b want 0", busy); else passed++;
  endtask

  task automatic test_reset_mid;
    int n_done;
    int cyc;
    @(negedge clk);
    expected = 4'b0101;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (tt_word !== 4'b0001) $display("FAIL rmid_tt_e2: got %b want 0001", tt_word);
    else passed++;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else passed++;
    checks++; if (sel_out !== 2'd0) $display("FAIL rmid_sel: got %0d want 0", sel_out);
    else passed++;
    checks++; if (tt_word !== 4'h0) $display("FAIL rmid_tt: got %b want 0000", tt_word);
    else passed++;
    rst_n  = 1'b1;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) n_done++;
    end
    checks++; if (n_done !== 0) $display("FAIL rmid_no_done: got %0d want 0", n_done);
    else passed++;
    sweep1(4'b0101, cyc);
    checks++; if (cyc !== 8) $display("FAIL rmid_fresh_latency: got %0d want 8", cyc);
    else passed++;
    checks++; if (match !== 1'b1) $display("FAIL rmid_fresh_match: got %b want 1", match);
    else passed++;
  endtask

  task automatic test_settle3;
    int cyc;
    logic [1:0] want_sel;
    @(negedge clk);
    expected2 = 4'b1111;
    start2    = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!done2 && cyc < 60) begin
      if (cyc < 16) begin
        want_sel = 2'(cyc / 4);
        checks++;
        if (sel_out2 !== want_sel)
          $display("FAIL s3_sel_e%0d: got %0d want %0d", cyc, sel_out2, want_sel);
        else passed++;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    checks++; if (cyc !== 16) $display("FAIL s3_latency: got %0d want 16", cyc); else passed++;
    checks++; if (tt_word2 !== 4'b1111) $display("FAIL s3_tt: got %b want 1111", tt_word2);
    else passed++;
    checks++; if (match2 !== 1'b1) $display("FAIL s3_match: got %b want 1", match2); else passed++;
  endtask

  task automatic test_start_vs_reset;
    @(negedge clk);
    start = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL sr_busy: got %b want 0", busy); else passed++;
    checks++; if (sel_out !== 2'd0) $display("FAIL sr_sel: got %0d want 0", sel_out);
    else passed++;
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL sr_busy_after: got %b want 0", busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mismatch();
    test_start_held();
    test_reset_mid();
    test_settle3();
    test_start_vs_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
